// File: rtl/tpu_cmd_bridge.sv
// Host-command bridge: parses framed UART commands into weight/activation/config/start
// actions for an N-column MLP core and returns ACK/NAK, status and result bytes.
module tpu_cmd_bridge #(
    parameter int N_COLS      = 2,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic [N_COLS-1:0]         wf_push,
    output logic [7:0]                wf_data,
    output logic                      wf_reset,
    output logic                      init_act_valid,
    output logic [8*N_COLS-1:0]       init_act_data,
    output logic                      start_mlp,
    output logic                      weights_ready,
    output logic [2:0]                vpu_activation_type,
    output logic [15:0]               norm_gain,
    output logic [31:0]               norm_bias,
    output logic [4:0]                norm_shift,
    output logic [15:0]               q_inv_scale,
    output logic [7:0]                q_zero_point,
    input  logic [3:0]                mlp_state,
    input  logic                      acc_valid,
    input  logic [ACC_W*N_COLS-1:0]   acc_in,
    output logic                      err
);

    localparam logic [3:0]  NC4       = 4'(N_COLS);
    localparam logic [8:0]  ACT_LAST  = 9'(N_COLS - 1);
    localparam logic [7:0]  RES_BYTES = 8'(ACC_W / 8);
    localparam logic [31:0] TO_CYC    = 32'(TIMEOUT_CYC);
    localparam logic [7:0]  ACK       = 8'hA5;
    localparam logic [7:0]  NAK       = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_LEN, S_GET_DATA, S_GET_ACT, S_GET_CFG, S_RESP, S_TX_MULTI
    } state_t;

    state_t state, state_n;

    logic [3:0]                opc, arg, arg_q;
    logic [8:0]                cnt;
    logic [7:0]                resp_byte, tx_left, status_byte;
    logic [ACC_W-1:0]          tx_shift, shadow_sel, acc_sel;
    logic                      is_status, result_valid, timeout_flag;
    logic [N_COLS-1:0]         loaded, col_onehot;
    logic [ACC_W*N_COLS-1:0]   shadow;
    logic [8*N_COLS-1:0]       act_buf, act_asm;
    logic [31:0]               cfg_buf, cfg_asm, tmr;
    logic                      in_get, to_hit;
    logic dec_ack, dec_nak, dec_status, dec_result, dec_start, dec_clear;
    logic w_push, w_last, act_byte, act_last, cfg_byte, cfg_last;
    logic tx_hs, tx_last, overrun, abort;

    assign opc           = rx_data[7:4];
    assign arg           = rx_data[3:0];
    assign weights_ready = &loaded;
    assign tx_valid      = (state == S_RESP) || (state == S_TX_MULTI);
    assign tx_data       = (state == S_RESP) ? resp_byte : tx_shift[7:0];
    assign status_byte   = {mlp_state != 4'd0, err, result_valid, timeout_flag, mlp_state};
    assign in_get        = (state == S_GET_LEN) || (state == S_GET_DATA) ||
                           (state == S_GET_ACT) || (state == S_GET_CFG);
    // tmr counts silent cycles since the last byte; abort on the TIMEOUT_CYC-th one
    assign to_hit        = (TO_CYC != 32'd0) && in_get && !rx_valid &&
                           (tmr == TO_CYC - 32'd1);

    always_comb begin
        shadow_sel = '0;
        acc_sel    = '0;
        col_onehot = '0;
        act_asm    = act_buf;
        cfg_asm    = cfg_buf;
        for (int i = 0; i < N_COLS; i++) begin
            if (arg == 4'(i)) begin
                shadow_sel = shadow[i*ACC_W +: ACC_W];
                acc_sel    = acc_in[i*ACC_W +: ACC_W];
            end
            if (arg_q == 4'(i)) col_onehot[i] = 1'b1;
            if (cnt == 9'(i)) act_asm[i*8 +: 8] = rx_data;
        end
        for (int i = 0; i < 4; i++) begin
            if (cnt == 9'(i)) cfg_asm[i*8 +: 8] = rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        dec_ack    = 1'b0;
        dec_nak    = 1'b0;
        dec_status = 1'b0;
        dec_result = 1'b0;
        dec_start  = 1'b0;
        dec_clear  = 1'b0;
        w_push     = 1'b0;
        w_last     = 1'b0;
        act_byte   = 1'b0;
        act_last   = 1'b0;
        cfg_byte   = 1'b0;
        cfg_last   = 1'b0;
        tx_hs      = 1'b0;
        tx_last    = 1'b0;
        overrun    = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: if (rx_valid) begin
                case (opc)
                    4'h1: if (arg < NC4) state_n = S_GET_LEN; else dec_nak = 1'b1;
                    4'h2: if (arg == 4'd0) state_n = S_GET_ACT; else dec_nak = 1'b1;
                    4'h3: if (arg <= 4'd5) state_n = S_GET_CFG; else dec_nak = 1'b1;
                    4'h4: if (arg == 4'd0 && mlp_state == 4'd0 && weights_ready) begin
                        dec_start = 1'b1;
                        dec_ack   = 1'b1;
                    end else dec_nak = 1'b1;
                    4'h5: if (arg == 4'd0) dec_status = 1'b1; else dec_nak = 1'b1;
                    4'h6: if (arg < NC4) dec_result = 1'b1; else dec_nak = 1'b1;
                    4'h7: if (arg == 4'd0) begin
                        dec_clear = 1'b1;
                        dec_ack   = 1'b1;
                    end else dec_nak = 1'b1;
                    default: dec_nak = 1'b1;
                endcase
                if (dec_ack || dec_nak)          state_n = S_RESP;
                else if (dec_status || dec_result) state_n = S_TX_MULTI;
            end
            S_GET_LEN: begin
                if (rx_valid)    state_n = S_GET_DATA;
                else if (to_hit) begin state_n = S_IDLE; abort = 1'b1; end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    w_push = 1'b1;
                    if (cnt == 9'd1) begin
                        w_last  = 1'b1;
                        dec_ack = 1'b1;
                        state_n = S_RESP;
                    end
                end else if (to_hit) begin state_n = S_IDLE; abort = 1'b1; end
            end
            S_GET_ACT: begin
                if (rx_valid) begin
                    act_byte = 1'b1;
                    if (cnt == ACT_LAST) begin
                        act_last = 1'b1;
                        dec_ack  = 1'b1;
                        state_n  = S_RESP;
                    end
                end else if (to_hit) begin state_n = S_IDLE; abort = 1'b1; end
            end
            S_GET_CFG: begin
                if (rx_valid) begin
                    cfg_byte = 1'b1;
                    if (cnt == 9'd3) begin
                        cfg_last = 1'b1;
                        dec_ack  = 1'b1;
                        state_n  = S_RESP;
                    end
                end else if (to_hit) begin state_n = S_IDLE; abort = 1'b1; end
            end
            S_RESP: begin
                overrun = rx_valid;
                if (tx_ready) state_n = S_IDLE;
            end
            S_TX_MULTI: begin
                overrun = rx_valid;
                if (tx_ready) begin
                    tx_hs = 1'b1;
                    if (tx_left == 8'd1) begin
                        tx_last = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_q               <= '0;
            cnt                 <= '0;
            resp_byte           <= '0;
            tx_left             <= '0;
            tx_shift            <= '0;
            is_status           <= 1'b0;
            result_valid        <= 1'b0;
            timeout_flag        <= 1'b0;
            err                 <= 1'b0;
            loaded              <= '0;
            shadow              <= '0;
            act_buf             <= '0;
            cfg_buf             <= '0;
            tmr                 <= '0;
            wf_push             <= '0;
            wf_data             <= '0;
            wf_reset            <= 1'b0;
            init_act_valid      <= 1'b0;
            init_act_data       <= '0;
            start_mlp           <= 1'b0;
            vpu_activation_type <= '0;
            norm_gain           <= 16'h0100;
            norm_bias           <= '0;
            norm_shift          <= '0;
            q_inv_scale         <= '0;
            q_zero_point        <= '0;
        end else begin
            wf_push        <= '0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            start_mlp      <= 1'b0;

            if (!in_get || rx_valid) tmr <= '0;
            else                     tmr <= tmr + 32'd1;

            if (state == S_IDLE && rx_valid) begin
                arg_q <= arg;
                cnt   <= '0;
            end
            if (state == S_GET_LEN && rx_valid)
                cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};

            if (w_push) begin
                wf_push <= col_onehot;
                wf_data <= rx_data;
                cnt     <= cnt - 9'd1;
            end
            if (dec_clear) begin
                wf_reset <= 1'b1;
                loaded   <= '0;
            end else if (w_last) begin
                loaded <= loaded | col_onehot;
            end

            // Partial activation/config bytes stay in the staging buffers until the last byte
            if (act_byte) begin
                act_buf <= act_asm;
                cnt     <= cnt + 9'd1;
            end
            if (act_last) begin
                init_act_data  <= act_asm;
                init_act_valid <= 1'b1;
            end
            if (cfg_byte) begin
                cfg_buf <= cfg_asm;
                cnt     <= cnt + 9'd1;
            end
            if (cfg_last) begin
                case (arg_q)
                    4'd0:    vpu_activation_type <= cfg_asm[2:0];
                    4'd1:    norm_gain           <= cfg_asm[15:0];
                    4'd2:    norm_bias           <= cfg_asm;
                    4'd3:    norm_shift          <= cfg_asm[4:0];
                    4'd4:    q_inv_scale         <= cfg_asm[15:0];
                    4'd5:    q_zero_point        <= cfg_asm[7:0];
                    default: ;
                endcase
            end

            if (dec_start) start_mlp <= 1'b1;
            if (dec_ack)   resp_byte <= ACK;
            if (dec_nak)   resp_byte <= NAK;

            if (dec_status) begin
                tx_shift      <= '0;
                tx_shift[7:0] <= status_byte;
                tx_left       <= 8'd1;
                is_status     <= 1'b1;
            end else if (dec_result) begin
                tx_shift  <= acc_valid ? acc_sel : shadow_sel;
                tx_left   <= RES_BYTES;
                is_status <= 1'b0;
            end else if (tx_hs) begin
                tx_shift <= tx_shift >> 8;
                tx_left  <= tx_left - 8'd1;
            end

            if (acc_valid) shadow <= acc_in;

            if (acc_valid)                   result_valid <= 1'b1;
            else if (tx_last && !is_status)  result_valid <= 1'b0;

            if (dec_nak || overrun || abort) err <= 1'b1;
            else if (tx_last && is_status)   err <= 1'b0;

            if (abort)                       timeout_flag <= 1'b1;
            else if (tx_last && is_status)   timeout_flag <= 1'b0;
        end
    end

endmodule
